// File: rtl/updown_counter_n.sv
// Parametrised up/down counter: load, enable, wrap pulse, sticky overflow.
// Build option UPDN_COUNTER_SAT_EN adds a sat input that saturates instead of wrapping.
module updown_counter_n #(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
`ifdef UPDN_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             sat_on;
  logic             at_edge;
  logic             step;
  logic             wrap_evt;
  logic             sat_evt;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;

`ifdef UPDN_COUNTER_SAT_EN
  assign sat_on = sat;
`else
  assign sat_on = 1'b0;
`endif

  assign step     = !load && en;
  assign at_edge  = dir ? (count_out == MAX_W) : (count_out == ZERO);
  assign wrap_evt = step && at_edge && !sat_on;
  assign sat_evt  = step && at_edge && sat_on;

  always_comb begin
    count_nxt = count_out;
    if (load) begin
      count_nxt = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (sat_evt)
        count_nxt = count_out;
      else if (dir)
        count_nxt = at_edge ? ZERO : count_out + ONE;
      else
        count_nxt = at_edge ? MAX_W : count_out - ONE;
    end
  end

  // Overflow set has priority over a simultaneous clear
  always_comb begin
    ovf_nxt = ovf;
    if (wrap_evt || sat_evt)
      ovf_nxt = 1'b1;
    else if (ovf_clr)
      ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out <= RST_W;
      wrap      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      count_out <= count_nxt;
      wrap      <= wrap_evt;
      ovf       <= ovf_nxt;
    end
  end

endmodule
